// File: rtl/host_to_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : host_to_bus_bridge
// Brief    : Async host RD_B/WR_B strobe interface to single-cycle BUS_CLK
//            bus accesses. Optional strobe timeout: HOST_BUS_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module host_to_bus_bridge #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h4000,
  parameter logic [ADDR_WIDTH-1:0] HIGH_ADDR   = 16'h7FFF,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    RD_LATENCY  = 1,
  parameter int                    TIMEOUT     = 255
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic [ADDR_WIDTH-1:0] ADD,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  RD_B,
  input  logic                  WR_B,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  RD_VALID,
  output logic [ADDR_WIDTH-1:0] BUS_ADD,
  output logic [DATA_WIDTH-1:0] BUS_DATA_WR,
  input  logic [DATA_WIDTH-1:0] BUS_DATA_RD,
  output logic                  BUS_RD,
  output logic                  BUS_WR,
  output logic                  CS_FPGA,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || RD_LATENCY < 0 || RD_LATENCY > 7 || TIMEOUT < 1)
  begin : g_param_check
    $error("host_to_bus_bridge: parameter out of legal range");
  end

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
  logic                   rd_hist, wr_hist;
  logic [FILL_W-1:0]      fill;
  logic [2:0]             lat_cnt;
  logic                   hit, filled, rd_last, wr_last, rd_fall, wr_fall;
  logic                   acc_wr, acc_rd, capture, set_err, tmo_hit;

  assign hit     = (ADD >= BASE_ADDR) && (ADD <= HIGH_ADDR);
  assign rd_last = rd_sync[SYNC_STAGES-1];
  assign wr_last = wr_sync[SYNC_STAGES-1];
  assign filled  = (fill == FILL_W'(SYNC_STAGES));
  assign rd_fall = rd_hist & ~rd_last;
  assign wr_fall = wr_hist & ~wr_last;

  // History is held low until the chain holds real pin samples, so a strobe
  // already low at reset release cannot look like a fresh falling edge.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      rd_sync <= '1;
      wr_sync <= '1;
      rd_hist <= 1'b1;
      wr_hist <= 1'b1;
      fill    <= '0;
    end else begin
      rd_sync <= {rd_sync[SYNC_STAGES-2:0], RD_B};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], WR_B};
      rd_hist <= filled ? rd_last : 1'b0;
      wr_hist <= filled ? wr_last : 1'b0;
      if (!filled) fill <= fill + FILL_W'(1);
    end
  end

`ifdef HOST_BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             strobe_low;

  assign strobe_low = ~(rd_last & wr_last);
  assign tmo_hit    = (state != IDLE) && strobe_low && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST)                                    tmo_cnt <= '0;
    else if (state == IDLE || !strobe_low || tmo_hit) tmo_cnt <= '0;
    else                                            tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    acc_wr     = 1'b0;
    acc_rd     = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_fall && wr_fall) begin
          set_err    = 1'b1;
          state_next = HOLD;
        end else if (wr_fall) begin
          acc_wr     = hit;
          state_next = HOLD;
        end else if (rd_fall) begin
          acc_rd     = hit;
          state_next = hit ? RD_WAIT : HOLD;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 3'd0) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD:    if (rd_last && wr_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (tmo_hit) begin
      capture    = 1'b0;
      set_err    = 1'b1;
      state_next = IDLE;
    end
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      BUS_WR      <= 1'b0;
      BUS_RD      <= 1'b0;
      RD_VALID    <= 1'b0;
      CS_FPGA     <= 1'b0;
      BUSY        <= 1'b0;
      ERR         <= 1'b0;
      BUS_ADD     <= '0;
      BUS_DATA_WR <= '0;
      DATA_OUT    <= '0;
      lat_cnt     <= 3'd0;
    end else begin
      BUS_WR   <= acc_wr;
      BUS_RD   <= acc_rd;
      RD_VALID <= capture;
      CS_FPGA  <= hit;
      // Stays high through the first IDLE cycle after HOLD.
      BUSY     <= (state_next != IDLE) || (state != IDLE);
      if (set_err)          ERR         <= 1'b1;
      if (acc_wr || acc_rd) BUS_ADD     <= ADD - BASE_ADDR;
      if (acc_wr)           BUS_DATA_WR <= DATA_IN;
      if (capture)          DATA_OUT    <= BUS_DATA_RD;
      if (acc_rd)                                      lat_cnt <= 3'(RD_LATENCY);
      else if (state == RD_WAIT && lat_cnt != 3'd0)    lat_cnt <= lat_cnt - 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_host_to_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_to_bus_bridge
// Brief    : Self-checking bench for host_to_bus_bridge (cycle model + literals).
// Revision : 1.0
// ============================================================================
module tb_host_to_bus_bridge;

  localparam int          SYNC = 2;
  localparam int          LAT  = 2;
  localparam int          TMO  = 20;
  localparam logic [15:0] BASE = 16'h4000;
  localparam logic [15:0] HIGH = 16'h7FFF;
  localparam int M_IDLE = 0, M_READ = 1, M_HOLD = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] add = '0;
  logic [7:0]  data_in = '0, bus_data_rd = '0;
  logic        rd_b = 1'b1, wr_b = 1'b1;
  logic [7:0]  data_out, bus_data_wr;
  logic [15:0] bus_add;
  logic        rd_valid, bus_rd, bus_wr, cs_fpga, busy, err;

  host_to_bus_bridge #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(BASE), .HIGH_ADDR(HIGH),
    .SYNC_STAGES(SYNC), .RD_LATENCY(LAT), .TIMEOUT(TMO)
  ) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .ADD(add), .DATA_IN(data_in),
    .RD_B(rd_b), .WR_B(wr_b), .DATA_OUT(data_out), .RD_VALID(rd_valid),
    .BUS_ADD(bus_add), .BUS_DATA_WR(bus_data_wr), .BUS_DATA_RD(bus_data_rd),
    .BUS_RD(bus_rd), .BUS_WR(bus_wr), .CS_FPGA(cs_fpga), .BUSY(busy), .ERR(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int wr_pulses = 0, rd_pulses = 0, rv_pulses = 0;
  int wr_cyc = 0, rd_cyc = 0, rv_cyc = 0, t0 = 0;
  logic [15:0] wr_add_seen, rd_add_seen;
  logic [7:0]  wr_dat_seen;

  // Model expectations for the current cycle.
  logic        e_bus_wr = 0, e_bus_rd = 0, e_rd_valid = 0, e_cs = 0, e_busy = 0, e_err = 0;
  logic [15:0] e_bus_add = '0;
  logic [7:0]  e_bus_data_wr = '0, e_data_out = '0;
  int          m_mode = M_IDLE, cap_edge = 0, low_run = 0;
  bit          samp_rd[$], samp_wr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pins are seen by the bridge SYNC edges after sampling; a falling edge
  // needs a high sample after reset followed by a low one.
  task automatic model_step();
    bit cur_r, cur_w, prv_r, prv_w, in_win, was_active, timed_out;
    int n;
    samp_rd.push_back(rd_b);
    samp_wr.push_back(wr_b);
    n = samp_rd.size();
    cur_r = (n - SYNC >= 1) ? samp_rd[n-SYNC-1] : 1'b1;
    cur_w = (n - SYNC >= 1) ? samp_wr[n-SYNC-1] : 1'b1;
    prv_r = (n - SYNC - 1 >= 1) ? samp_rd[n-SYNC-2] : 1'b0;
    prv_w = (n - SYNC - 1 >= 1) ? samp_wr[n-SYNC-2] : 1'b0;
    in_win = (add >= BASE) && (add <= HIGH);
    was_active = (m_mode != M_IDLE);
    e_bus_wr = 0; e_bus_rd = 0; e_rd_valid = 0;
    e_cs = in_win;
    timed_out = 0;
`ifdef HOST_BUS_TIMEOUT_EN
    if (m_mode == M_IDLE) low_run = 0;
    else begin
      low_run = (!cur_r || !cur_w) ? low_run + 1 : 0;
      if (low_run == TMO) begin
        timed_out = 1; e_err = 1; m_mode = M_IDLE; low_run = 0;
      end
    end
`endif
    if (!timed_out) begin
      case (m_mode)
        M_IDLE: begin
          if (!cur_r && prv_r && !cur_w && prv_w) begin
            e_err = 1; m_mode = M_HOLD;
          end else if (!cur_w && prv_w) begin
            if (in_win) begin
              e_bus_wr = 1; e_bus_add = add - BASE; e_bus_data_wr = data_in;
            end
            m_mode = M_HOLD;
          end else if (!cur_r && prv_r) begin
            if (in_win) begin
              e_bus_rd = 1; e_bus_add = add - BASE; cap_edge = n + 1 + LAT; m_mode = M_READ;
            end else m_mode = M_HOLD;
          end
        end
        M_READ: if (n == cap_edge) begin
          e_data_out = bus_data_rd; e_rd_valid = 1; m_mode = M_HOLD;
        end
        default: if (cur_r && cur_w) m_mode = M_IDLE;
      endcase
    end
    e_busy = was_active || (m_mode != M_IDLE);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      e_bus_wr = 0; e_bus_rd = 0; e_rd_valid = 0; e_cs = 0; e_busy = 0; e_err = 0;
      e_bus_add = '0; e_bus_data_wr = '0; e_data_out = '0;
      m_mode = M_IDLE; low_run = 0;
      samp_rd.delete(); samp_wr.delete();
    end else model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    chk("bus_wr", bus_wr, e_bus_wr);
    chk("bus_rd", bus_rd, e_bus_rd);
    chk("rd_valid", rd_valid, e_rd_valid);
    chk("cs_fpga", cs_fpga, e_cs);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
    chk("bus_add", bus_add, e_bus_add);
    chk("bus_data_wr", bus_data_wr, e_bus_data_wr);
    chk("data_out", data_out, e_data_out);
    if (bus_wr === 1'b1) begin
      wr_pulses++; wr_cyc = cyc; wr_add_seen = bus_add; wr_dat_seen = bus_data_wr;
    end
    if (bus_rd === 1'b1) begin
      rd_pulses++; rd_cyc = cyc; rd_add_seen = bus_add;
    end
    if (rd_valid === 1'b1) begin
      rv_pulses++; rv_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic access(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                        input int low_n, input int high_n);
    add = a; data_in = d; t0 = cyc;
    if (is_wr) wr_b = 1'b0; else rd_b = 1'b0;
    step(low_n);
    wr_b = 1'b1; rd_b = 1'b1;
    step(high_n);
  endtask

  initial begin
    int wr0, rd0, rv0;
    bit seen;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_data_out", data_out, 0);
    rst = 1'b0;
    step(6);

    // Write inside the window.
    wr0 = wr_pulses;
    access(1'b1, 16'h4012, 8'hA5, 10, 8);
    chk("wr_count", wr_pulses - wr0, 1);
    chk("wr_edge", wr_cyc - t0, 3);
    chk("wr_bus_add", wr_add_seen, 16'h0012);
    chk("wr_bus_data", wr_dat_seen, 8'hA5);
    chk("wr_busy_end", busy, 0);

    // Read at the top of the window.
    rd0 = rd_pulses; rv0 = rv_pulses;
    bus_data_rd = 8'h3C;
    access(1'b0, 16'h7FFF, 8'h00, 12, 8);
    chk("rd_count", rd_pulses - rd0, 1);
    chk("rd_bus_add", rd_add_seen, 16'h3FFF);
    chk("rd_valid_count", rv_pulses - rv0, 1);
    chk("rd_valid_delay", rv_cyc - rd_cyc, 3);
    chk("rd_data_out", data_out, 8'h3C);

    // Just outside either end of the window.
    wr0 = wr_pulses;
    access(1'b1, 16'h8000, 8'h11, 6, 6);
    access(1'b1, 16'h3FFF, 8'h22, 6, 6);
    chk("oow_wr_count", wr_pulses - wr0, 0);
    chk("oow_cs", cs_fpga, 0);
    chk("oow_err", err, 0);

    // Base address and another read pattern.
    access(1'b1, 16'h4000, 8'hFF, 7, 6);
    chk("base_wr_add", wr_add_seen, 16'h0000);
    bus_data_rd = 8'h5A;
    access(1'b0, 16'h4ABC, 8'h00, 9, 6);
    chk("rd2_add", rd_add_seen, 16'h0ABC);
    chk("rd2_data_out", data_out, 8'h5A);

    // Simultaneous strobes.
    wr0 = wr_pulses; rd0 = rd_pulses;
    add = 16'h4100; rd_b = 1'b0; wr_b = 1'b0;
    step(6);
    rd_b = 1'b1; wr_b = 1'b1;
    step(6);
    chk("sim_no_wr", wr_pulses - wr0, 0);
    chk("sim_no_rd", rd_pulses - rd0, 0);
    chk("sim_err", err, 1);
    access(1'b1, 16'h4200, 8'h33, 6, 6);
    chk("sim_err_sticky", err, 1);

    // Reset while waiting for read data, strobe still low afterwards.
    add = 16'h4020; bus_data_rd = 8'h77; rd_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #2;
      if (bus_rd === 1'b1) seen = 1;
    end
    chk("rstrd_bus_rd_seen", seen, 1);
    rd0 = rd_pulses;
    #1 rst = 1'b1;
    #1;
    chk("rstrd_bus_rd", bus_rd, 0);
    chk("rstrd_busy", busy, 0);
    chk("rstrd_err", err, 0);
    chk("rstrd_data_out", data_out, 0);
    chk("rstrd_bus_add", bus_add, 0);
    chk("rstrd_bus_data_wr", bus_data_wr, 0);
    chk("rstrd_cs", cs_fpga, 0);
    step(2);
    rst = 1'b0;
    step(10);
    chk("rstrd_no_replay", rd_pulses - rd0, 0);
    rd_b = 1'b1;
    step(6);
    access(1'b0, 16'h4020, 8'h00, 10, 6);
    chk("rstrd_new_read", rd_pulses - rd0, 1);
    chk("rstrd_new_data", data_out, 8'h77);

`ifdef HOST_BUS_TIMEOUT_EN
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(6);
    wr0 = wr_pulses;
    add = 16'h4001; data_in = 8'h9C; wr_b = 1'b0; t0 = cyc;
    step(30);
    chk("tmo_busy", busy, 0);
    chk("tmo_err", err, 1);
    step(20);
    wr_b = 1'b1;
    step(8);
    chk("tmo_wr_count", wr_pulses - wr0, 1);
`endif

    step(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
